// File: rtl/mult_issue_sequencer_if.sv
// Bundles the operand-in, multiplier-side, result-out and status signals of the issue sequencer.
// The master modport is the sequencer's view; slave is the view of the surrounding logic.
interface mult_issue_sequencer_if;
    logic        in_valid;
    logic [15:0] in_mtp;
    logic [15:0] in_mtc;
    logic        in_ready;

    logic        mult_St;
    logic [15:0] mult_Mtp;
    logic [15:0] mult_Mtc;
    logic        mult_Done;
    logic [31:0] mult_Product;

    logic        out_valid;
    logic [31:0] out_product;
    logic        out_ready;

    logic        busy;
    logic        err_timeout;
    logic [7:0]  done_count;

    modport master (
        input  in_valid, in_mtp, in_mtc,
        output in_ready,
        output mult_St, mult_Mtp, mult_Mtc,
        input  mult_Done, mult_Product,
        output out_valid, out_product,
        input  out_ready,
        output busy, err_timeout, done_count
    );

    modport slave (
        output in_valid, in_mtp, in_mtc,
        input  in_ready,
        input  mult_St, mult_Mtp, mult_Mtc,
        output mult_Done, mult_Product,
        input  out_valid, out_product,
        output out_ready,
        input  busy, err_timeout, done_count
    );
endinterface

// File: rtl/mult_issue_sequencer.sv
// Queues signed operand pairs and issues them one at a time to a St/Done sequential multiplier, min 4 cycles per issue.
// Backpressure: in_ready drops when the FIFO is full; no issue while an unconsumed result occupies the output slot.
module mult_issue_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mult_issue_sequencer_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FULL_LVL = FW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        WAIT_LOW
    } state_e;

    state_e state_q, state_d;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FW-1:0] fill_q, fill_d;
    logic          push;
    logic          pop;

    logic [15:0]   mtp_q, mtp_d;
    logic [15:0]   mtc_q, mtc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          out_vld_q, out_vld_d;
    logic [31:0]   out_dat_q, out_dat_d;
    logic          err_q, err_d;
    logic [7:0]    cnt_q, cnt_d;

    logic slot_free;
    logic fifo_nempty;

    // in_ready looks only at registered fill, so a same-cycle pop never opens a slot combinationally
    assign bus.in_ready = (fill_q < FULL_LVL);
    assign push         = bus.in_valid && bus.in_ready;
    assign fifo_nempty  = (fill_q != '0);
    assign slot_free    = !out_vld_q || bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        mtp_d     = mtp_q;
        mtc_d     = mtc_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        if (out_vld_q && bus.out_ready) begin
            out_vld_d = 1'b0;
            out_dat_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (fifo_nempty && slot_free) begin
                    pop     = 1'b1;
                    mtp_d   = mem_q[rd_ptr_q][31:16];
                    mtc_d   = mem_q[rd_ptr_q][15:0];
                    state_d = START;
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.mult_Done) begin
                    // a capture here overrides any same-cycle handshake clear above
                    out_vld_d = 1'b1;
                    out_dat_d = bus.mult_Product;
                    cnt_d     = cnt_q + 8'd1;
                    state_d   = WAIT_LOW;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!bus.mult_Done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            fill_q    <= '0;
            mtp_q     <= '0;
            mtc_q     <= '0;
            tmo_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            fill_q    <= fill_d;
            mtp_q     <= mtp_d;
            mtc_q     <= mtc_d;
            tmo_q     <= tmo_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // storage needs no reset: fill and pointers decide which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.in_mtp, bus.in_mtc};
        end
    end

    assign bus.mult_St     = (state_q == START);
    assign bus.mult_Mtp    = mtp_q;
    assign bus.mult_Mtc    = mtc_q;
    assign bus.out_valid   = out_vld_q;
    assign bus.out_product = out_dat_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.err_timeout = err_q;
    assign bus.done_count  = cnt_q;
endmodule

// File: tb/tb_mult_issue_sequencer.sv
// Randomized scoreboard bench for mult_issue_sequencer with a behavioural St/Done multiplier model.
module tb_mult_issue_sequencer;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic clk;
    logic reset_n;

    mult_issue_sequencer_if bus();

    mult_issue_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] iss_q[$];
    logic [31:0] exp_q[$];
    int st_count = 0;
    int exp_done = 0;
    int exp_st   = 0;

    int mul_lat   = 10;
    int mul_hold  = 1;
    bit mul_never = 1'b0;
    bit mul_rand  = 1'b0;
    int rdy_mode  = 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [31:0] ref_prod(input logic [31:0] pair);
        logic signed [15:0] a;
        logic signed [15:0] b;
        logic signed [31:0] p;
        a = pair[31:16];
        b = pair[15:0];
        p = a * b;
        return p;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_mtp   = a;
        bus.in_mtc   = b;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            k++;
            if (k >= 300) break;
        end
        if (k >= 300) fail_now("push_timeout in_ready never rose");
        else iss_q.push_back({a, b});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if (iss_q.size() == 0 && exp_q.size() == 0 && !bus.busy && !bus.out_valid) break;
            k++;
            if (k >= 3000) break;
        end
        if (k >= 3000) fail_now("drain_timeout results outstanding");
        @(posedge clk);
        #1;
    endtask

    // multiplier model: Done rises mul_lat cycles after St and stays for mul_hold cycles
    logic [15:0] ma, mb;
    bit          m_active = 1'b0;
    int          m_cnt, m_hl;
    bit          st_now;
    logic [31:0] pr;
    initial begin
        bus.mult_Done    = 1'b0;
        bus.mult_Product = 32'h0;
        forever begin
            @(negedge clk);
            st_now = reset_n && bus.mult_St;
            if (st_now) begin
                chk("st_while_mult_busy", {31'h0, m_active}, 32'h0);
                st_count++;
                if (iss_q.size() == 0) fail_now("st_without_pending_pair");
                else begin
                    pr = iss_q.pop_front();
                    chk("issue_operands", {bus.mult_Mtp, bus.mult_Mtc}, pr);
                    if (!mul_never) exp_q.push_back(ref_prod(pr));
                end
                ma = bus.mult_Mtp;
                mb = bus.mult_Mtc;
            end else if (m_active) begin
                chk("operand_hold", {bus.mult_Mtp, bus.mult_Mtc}, {ma, mb});
            end
            @(posedge clk);
            #1;
            if (!reset_n) begin
                m_active         = 1'b0;
                bus.mult_Done    = 1'b0;
                bus.mult_Product = 32'h0;
            end else if (st_now) begin
                if (!mul_never) begin
                    m_active = 1'b1;
                    m_cnt    = mul_rand ? int'($urandom_range(1, 6)) : mul_lat;
                end
            end else if (m_active) begin
                if (!bus.mult_Done) begin
                    m_cnt--;
                    if (m_cnt <= 0) begin
                        bus.mult_Done    = 1'b1;
                        bus.mult_Product = ref_prod({ma, mb});
                        m_hl = mul_rand ? int'($urandom_range(1, 3)) : mul_hold;
                    end
                end else begin
                    m_hl--;
                    if (m_hl <= 0) begin
                        bus.mult_Done    = 1'b0;
                        bus.mult_Product = 32'h0;
                        m_active         = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // output monitor: stability while stalled, in-order compare on each handshake
    logic        pv = 1'b0;
    logic [31:0] pd;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0;
            end else if (bus.out_valid) begin
                if (pv) chk("out_product_hold", bus.out_product, pd);
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_result");
                    else chk("product", bus.out_product, exp_q.pop_front());
                    pv = 1'b0;
                end else begin
                    pv = 1'b1;
                    pd = bus.out_product;
                end
            end else begin
                if (pv) fail_now("out_valid_dropped_unconsumed");
                pv = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int st0;
        int k;
        bit seen;
        bus.in_valid = 1'b0;
        bus.in_mtp   = 16'h0;
        bus.in_mtc   = 16'h0;
        reset_n      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("rst_mult_St", {31'h0, bus.mult_St}, 32'h0);
        chk("rst_operands", {bus.mult_Mtp, bus.mult_Mtc}, 32'h0);
        chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("rst_out_product", bus.out_product, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_err", {31'h0, bus.err_timeout}, 32'h0);
        chk("rst_done_count", {24'h0, bus.done_count}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc(2);

        // single pair 3*3, Done after 10 cycles
        push(16'd3, 16'd3);
        exp_done += 1; exp_st += 1;
        drain();
        chk("single_done_count", {24'h0, bus.done_count}, exp_done);
        chk("single_st_pulses", st_count, exp_st);

        // mixed signs back-to-back
        push(16'hFFFD, 16'd3);
        push(16'd3, 16'hFFFD);
        push(16'hFFFD, 16'hFFFD);
        exp_done += 3; exp_st += 3;
        drain();
        chk("signs_done_count", {24'h0, bus.done_count}, exp_done);
        chk("signs_st_pulses", st_count, exp_st);

        // random operands, latencies, hold lengths, gaps and consumer stalls
        mul_rand = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 3));
            push(16'($urandom()), 16'($urandom()));
        end
        exp_done += 40; exp_st += 40;
        rdy_mode = 1;
        drain();
        mul_rand = 1'b0;
        chk("rand_done_count", {24'h0, bus.done_count}, exp_done);
        chk("rand_st_pulses", st_count, exp_st);

        // consumer stalled: 1 issued + 4 queued fills the FIFO, no further issue
        rdy_mode = 0;
        cyc(2);
        st0 = st_count;
        for (int i = 0; i < 5; i++) push(16'(i + 1), 16'(-(i + 2)));
        @(negedge clk);
        chk("full_in_ready", {31'h0, bus.in_ready}, 32'h0);
        cyc(30);
        @(negedge clk);
        chk("stall_in_ready", {31'h0, bus.in_ready}, 32'h0);
        chk("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("stall_single_st", st_count - st0, 32'd1);
        @(posedge clk);
        #1;
        rdy_mode = 1;
        push(16'd7, 16'd7);
        exp_done += 6; exp_st += 6;
        drain();
        chk("stall_done_count", {24'h0, bus.done_count}, exp_done);

        // Done held high for several cycles counts once
        mul_hold = 5;
        push(16'hFF9C, 16'd250);
        exp_done += 1; exp_st += 1;
        drain();
        mul_hold = 1;
        chk("long_done_count", {24'h0, bus.done_count}, exp_done);
        chk("long_done_st", st_count, exp_st);

        // multiplier never answers
        mul_never = 1'b1;
        push(16'd5, 16'd6);
        exp_st += 1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mult_St) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("timeout_pair_never_issued");
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (bus.out_valid) fail_now("timeout_out_valid_set");
            if (bus.err_timeout || k >= 500) break;
        end
        chk("timeout_cycles", k, TMO + 1);
        chk("timeout_busy", {31'h0, bus.busy}, 32'h0);
        @(posedge clk);
        #1;
        mul_never = 1'b0;
        push(16'd11, 16'hFFF4);
        exp_done += 1; exp_st += 1;
        drain();
        chk("timeout_sticky", {31'h0, bus.err_timeout}, 32'h1);
        chk("after_timeout_done_count", {24'h0, bus.done_count}, exp_done);
        chk("after_timeout_st", st_count, exp_st);

        // reset during WAIT_DONE with two pairs queued
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        cyc(3);
        @(negedge clk);
        chk("pre_reset_busy", {31'h0, bus.busy}, 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        chk("mid_rst_st", {31'h0, bus.mult_St}, 32'h0);
        chk("mid_rst_operands", {bus.mult_Mtp, bus.mult_Mtc}, 32'h0);
        chk("mid_rst_out", {31'h0, bus.out_valid}, 32'h0);
        chk("mid_rst_product", bus.out_product, 32'h0);
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("mid_rst_err", {31'h0, bus.err_timeout}, 32'h0);
        chk("mid_rst_done_count", {24'h0, bus.done_count}, 32'h0);
        iss_q.delete();
        exp_q.delete();
        exp_done = 0;
        cyc(2);
        reset_n = 1'b1;
        st0 = st_count;
        cyc(30);
        @(negedge clk);
        chk("post_rst_no_st", st_count - st0, 32'd0);
        chk("post_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("post_rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk);
        #1;
        push(16'd2, 16'hFFF8);
        exp_done += 1;
        drain();
        chk("post_rst_done_count", {24'h0, bus.done_count}, exp_done);
        chk("post_rst_err", {31'h0, bus.err_timeout}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
